// File: rtl/logic_ni_pkg.sv
// Shared definitions for the logic NI packet stream: word types, field positions,
// reserved-bit masks, receiver state encoding and the reassembled record layout.
package logic_ni_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned OSC_W  = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PAR_W  = 8;

    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned TYPE_LSB = 30;
    localparam int unsigned ID_MSB   = 9;
    localparam int unsigned ID_LSB   = 5;
    localparam int unsigned OSC_MSB  = 4;
    localparam int unsigned OSC_LSB  = 0;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned PAR_MSB  = 7;
    localparam int unsigned PAR_LSB  = 0;

    // Reserved bits that must be zero in each word type
    localparam logic [WORD_W-1:0] HEAD_RSV_MASK = 32'h3FFF_FC00;
    localparam logic [WORD_W-1:0] BODY_RSV_MASK = 32'h3FFF_0000;
    localparam logic [WORD_W-1:0] TAIL_RSV_MASK = 32'h3FFF_FF00;

    typedef enum logic [1:0] {
        PKT_HEAD = 2'b00,
        PKT_BODY = 2'b01,
        PKT_ILL  = 2'b10,
        PKT_TAIL = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        W_HEAD = 2'd0,
        W_BODY = 2'd1,
        W_TAIL = 2'd2,
        OUT    = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [OSC_W-1:0]  osc;
        logic [DATA_W-1:0] data;
        logic              parity_err;
        logic              frame_err;
    } ni_rec_t;

    function automatic pkt_type_e word_type(input logic [WORD_W-1:0] word);
        return pkt_type_e'(word[TYPE_MSB:TYPE_LSB]);
    endfunction

endpackage

// File: rtl/logic_ni_rx_if.sv
// FIFO-side and record-side signals of the logic NI receiver.
interface logic_ni_rx_if
    import logic_ni_pkg::*;
#(
    parameter int unsigned CntWidth = 16
);
    logic                FifoEmpty_i;
    logic                FifoRd_o;
    logic [WORD_W-1:0]   FifoRdData_i;
    logic                RecValid_o;
    logic                RecReady_i;
    logic [ID_W-1:0]     RecId_o;
    logic [OSC_W-1:0]    RecOsc_o;
    logic [DATA_W-1:0]   RecData_o;
    logic                RecParityErr_o;
    logic                RecFrameErr_o;
    logic                RoundDone_o;
    logic [CntWidth-1:0] PktCnt_o;
    logic [CntWidth-1:0] ErrCnt_o;

    // Receiver view
    modport slave (
        input  FifoEmpty_i, FifoRdData_i, RecReady_i,
        output FifoRd_o, RecValid_o, RecId_o, RecOsc_o, RecData_o,
               RecParityErr_o, RecFrameErr_o, RoundDone_o, PktCnt_o, ErrCnt_o
    );

    // FIFO source / record consumer view
    modport master (
        output FifoEmpty_i, FifoRdData_i, RecReady_i,
        input  FifoRd_o, RecValid_o, RecId_o, RecOsc_o, RecData_o,
               RecParityErr_o, RecFrameErr_o, RoundDone_o, PktCnt_o, ErrCnt_o
    );
endinterface

// File: rtl/logic_ni_parity_chk.sv
// Checks the two TAIL parity bits that depend only on transmitted count bits [23:12].
module logic_ni_parity_chk
    import logic_ni_pkg::*;
(
    input  logic [DATA_W-1:0] payload,
    input  logic [PAR_W-1:0]  parity,
    output logic              err_c
);
    logic exp_p3;
    logic exp_p2;
    logic unused_bits;

    // payload[15:0] carries count[23:8]
    assign exp_p3 = ~^payload[15:10];
    assign exp_p2 = ~^payload[9:4];
    assign err_c  = (parity[3] != exp_p3) | (parity[2] != exp_p2);

    assign unused_bits = ^{payload[3:0], parity[7:4], parity[1:0]};
endmodule

// File: rtl/logic_ni_rx.sv
// Logic NI receiver: pops HEAD/BODY/TAIL words from an FWFT FIFO, rebuilds one
// record per packet, flags framing/parity errors and keeps saturating counters.
module logic_ni_rx
    import logic_ni_pkg::*;
#(
    parameter int unsigned NumOsc   = 25,
    parameter int unsigned CntWidth = 16
) (
    input  logic          clk,
    input  logic          rstn,
    logic_ni_rx_if.slave  bus
);
    rx_state_e           state, state_nxt;
    ni_rec_t             rec_q;
    logic [ID_W-1:0]     id_q;
    logic [OSC_W-1:0]    osc_q;
    logic [DATA_W-1:0]   data_q;
    logic                rsv_q;
    logic                sticky_q;
    logic [CntWidth-1:0] pkt_cnt;
    logic [CntWidth-1:0] err_cnt;

    logic [WORD_W-1:0]   word;
    pkt_type_e           typ;
    logic                pop, accept, ld_head, ld_body, ld_tail, resync, bad_word;
    logic                head_rsv, body_rsv, tail_rsv, par_err;
    logic [1:0]          err_inc;
    logic [CntWidth:0]   pkt_sum, err_sum;

    assign word     = bus.FifoRdData_i;
    assign typ      = word_type(word);
    assign head_rsv = |(word & HEAD_RSV_MASK);
    assign body_rsv = |(word & BODY_RSV_MASK);
    assign tail_rsv = |(word & TAIL_RSV_MASK);

    logic_ni_parity_chk u_parity_chk (
        .payload (data_q),
        .parity  (word[PAR_MSB:PAR_LSB]),
        .err_c   (par_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= W_HEAD;
        else       state <= state_nxt;
    end

    // Next state and per-word load/drop decisions
    always_comb begin
        state_nxt = state;
        ld_head   = 1'b0;
        ld_body   = 1'b0;
        ld_tail   = 1'b0;
        resync    = 1'b0;
        bad_word  = 1'b0;
        pop       = ~bus.FifoEmpty_i & (state != OUT);
        accept    = (state == OUT) & bus.RecReady_i;
        unique case (state)
            W_HEAD: if (pop) begin
                if (typ == PKT_HEAD) begin
                    ld_head   = 1'b1;
                    state_nxt = W_BODY;
                end else begin
                    bad_word  = 1'b1;
                end
            end
            W_BODY: if (pop) begin
                if (typ == PKT_BODY) begin
                    ld_body   = 1'b1;
                    state_nxt = W_TAIL;
                end else if (typ == PKT_HEAD) begin
                    ld_head   = 1'b1;
                    resync    = 1'b1;
                    bad_word  = 1'b1;
                end else begin
                    bad_word  = 1'b1;
                    state_nxt = W_HEAD;
                end
            end
            W_TAIL: if (pop) begin
                if (typ == PKT_TAIL) begin
                    ld_tail   = 1'b1;
                    state_nxt = OUT;
                end else if (typ == PKT_HEAD) begin
                    ld_head   = 1'b1;
                    resync    = 1'b1;
                    bad_word  = 1'b1;
                    state_nxt = W_BODY;
                end else begin
                    bad_word  = 1'b1;
                    state_nxt = W_HEAD;
                end
            end
            OUT: if (accept) state_nxt = W_HEAD;
        endcase
    end

    // Packet assembly and record register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q     <= '0;
            osc_q    <= '0;
            data_q   <= '0;
            rsv_q    <= 1'b0;
            sticky_q <= 1'b0;
            rec_q    <= '0;
        end else begin
            if (ld_head) begin
                id_q  <= word[ID_MSB:ID_LSB];
                osc_q <= word[OSC_MSB:OSC_LSB];
                rsv_q <= head_rsv;
            end
            if (ld_body) begin
                data_q <= word[DATA_MSB:DATA_LSB];
                rsv_q  <= rsv_q | body_rsv;
            end
            if (ld_tail) begin
                rec_q <= '{id: id_q, osc: osc_q, data: data_q, parity_err: par_err,
                           frame_err: sticky_q | rsv_q | tail_rsv};
            end
            if (resync)      sticky_q <= 1'b1;
            else if (accept) sticky_q <= 1'b0;
        end
    end

    // Saturating counters; a dropped word and an errored accept can coincide
    assign err_inc = 2'(bad_word) + 2'(accept & (rec_q.parity_err | rec_q.frame_err));
    assign err_sum = {1'b0, err_cnt} + (CntWidth+1)'(err_inc);
    assign pkt_sum = {1'b0, pkt_cnt} + (CntWidth+1)'(accept);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            pkt_cnt <= pkt_sum[CntWidth] ? '1 : pkt_sum[CntWidth-1:0];
            err_cnt <= err_sum[CntWidth] ? '1 : err_sum[CntWidth-1:0];
        end
    end

    assign bus.FifoRd_o       = pop & rstn;
    assign bus.RecValid_o     = (state == OUT);
    assign bus.RecId_o        = rec_q.id;
    assign bus.RecOsc_o       = rec_q.osc;
    assign bus.RecData_o      = rec_q.data;
    assign bus.RecParityErr_o = rec_q.parity_err;
    assign bus.RecFrameErr_o  = rec_q.frame_err;
    assign bus.RoundDone_o    = accept & (rec_q.osc == OSC_W'(NumOsc - 1));
    assign bus.PktCnt_o       = pkt_cnt;
    assign bus.ErrCnt_o       = err_cnt;
endmodule

// File: tb/tb_logic_ni_rx.sv
// Directed bench for logic_ni_rx: table of packets plus hand sequences for
// backpressure, resync, garbage/round-done and mid-packet reset.
module tb_logic_ni_rx;
    import logic_ni_pkg::*;

    typedef struct {
        logic [31:0] head;
        logic [31:0] body;
        logic [31:0] tail;
        logic [4:0]  id;
        logic [4:0]  osc;
        logic [15:0] data;
        logic        par;
        logic        frame;
        logic        round;
        int          pkt;
        int          err;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic_ni_rx_if #(.CntWidth(16)) bus ();

    logic_ni_rx #(.NumOsc(25), .CntWidth(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // FWFT FIFO model
    logic [31:0] fifo_mem [0:63];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pop_cnt = 0;

    assign bus.FifoEmpty_i  = (wr_ptr == rd_ptr);
    assign bus.FifoRdData_i = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (bus.FifoRd_o === 1'b1) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_pkt(input logic [31:0] h, input logic [31:0] b, input logic [31:0] t);
        push(h);
        push(b);
        push(t);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.RecValid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rec_valid_seen", 32'(bus.RecValid_o), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   n;
        int   base;

        vecs[0] = '{32'h0000_0143, 32'h4000_ABCD, 32'hC000_0004, 5'd10, 5'd3,  16'hABCD, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[1] = '{32'h0000_0143, 32'h4000_ABCD, 32'hC000_0008, 5'd10, 5'd3,  16'hABCD, 1'b1, 1'b0, 1'b0, 2, 1};
        vecs[2] = '{32'h0000_03E7, 32'h4001_1234, 32'hC000_0000, 5'd31, 5'd7,  16'h1234, 1'b0, 1'b1, 1'b0, 3, 2};
        vecs[3] = '{32'h0000_0000, 32'h4000_FFFF, 32'hC000_00FF, 5'd0,  5'd0,  16'hFFFF, 1'b0, 1'b0, 1'b0, 4, 2};
        vecs[4] = '{32'h0000_0038, 32'h4000_0000, 32'hC000_0000, 5'd1,  5'd24, 16'h0000, 1'b1, 1'b0, 1'b1, 5, 3};
        vecs[5] = '{32'h0000_0143, 32'h4000_ABCD, 32'hC000_0104, 5'd10, 5'd3,  16'hABCD, 1'b0, 1'b1, 1'b0, 6, 4};

        bus.RecReady_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(bus.RecValid_o), 32'd0);
        chk("reset_fifo_rd", 32'(bus.FifoRd_o), 32'd0);
        chk("reset_pkt_cnt", 32'(bus.PktCnt_o), 32'd0);
        chk("reset_err_cnt", 32'(bus.ErrCnt_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            push_pkt(vecs[i].head, vecs[i].body, vecs[i].tail);
            wait_valid(n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'd3);
            chk($sformatf("v%0d_id", i), 32'(bus.RecId_o), 32'(vecs[i].id));
            chk($sformatf("v%0d_osc", i), 32'(bus.RecOsc_o), 32'(vecs[i].osc));
            chk($sformatf("v%0d_data", i), 32'(bus.RecData_o), 32'(vecs[i].data));
            chk($sformatf("v%0d_parity_err", i), 32'(bus.RecParityErr_o), 32'(vecs[i].par));
            chk($sformatf("v%0d_frame_err", i), 32'(bus.RecFrameErr_o), 32'(vecs[i].frame));
            chk($sformatf("v%0d_round_done", i), 32'(bus.RoundDone_o), 32'(vecs[i].round));
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), 32'(bus.RecValid_o), 32'd0);
            chk($sformatf("v%0d_pkt_cnt", i), 32'(bus.PktCnt_o), 32'(vecs[i].pkt));
            chk($sformatf("v%0d_err_cnt", i), 32'(bus.ErrCnt_o), 32'(vecs[i].err));
        end

        // Backpressure: record held, no pops, next packet resumes after accept
        do_reset();
        bus.RecReady_i = 1'b0;
        base = pop_cnt;
        push_pkt(32'h0000_0143, 32'h4000_ABCD, 32'hC000_0004);
        push_pkt(32'h0000_0041, 32'h4000_ABCD, 32'hC000_0004);
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(bus.RecValid_o), 32'd1);
            chk("bp_fifo_rd", 32'(bus.FifoRd_o), 32'd0);
            chk("bp_id", 32'(bus.RecId_o), 32'd10);
            chk("bp_data", 32'(bus.RecData_o), 32'hABCD);
            chk("bp_pops", 32'(pop_cnt - base), 32'd3);
            @(negedge clk);
        end
        bus.RecReady_i = 1'b1;
        #1;
        chk("bp_round_low", 32'(bus.RoundDone_o), 32'd0);
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.RecValid_o), 32'd0);
        chk("bp_after_pops", 32'(pop_cnt - base), 32'd3);
        chk("bp_after_fifo_rd", 32'(bus.FifoRd_o), 32'd1);
        chk("bp_after_pkt", 32'(bus.PktCnt_o), 32'd1);
        wait_valid(n);
        chk("bp2_latency", 32'(n), 32'd3);
        chk("bp2_id", 32'(bus.RecId_o), 32'd2);
        chk("bp2_osc", 32'(bus.RecOsc_o), 32'd1);
        chk("bp2_pops", 32'(pop_cnt - base), 32'd6);
        @(negedge clk);
        chk("bp2_pkt", 32'(bus.PktCnt_o), 32'd2);
        chk("bp2_err", 32'(bus.ErrCnt_o), 32'd0);

        // Resync on a second HEAD while waiting for BODY
        do_reset();
        push(32'h0000_0040);
        push(32'h0000_0041);
        push(32'h4000_ABCD);
        push(32'hC000_0004);
        wait_valid(n);
        chk("rs_latency", 32'(n), 32'd4);
        chk("rs_id", 32'(bus.RecId_o), 32'd2);
        chk("rs_osc", 32'(bus.RecOsc_o), 32'd1);
        chk("rs_frame_err", 32'(bus.RecFrameErr_o), 32'd1);
        chk("rs_parity_err", 32'(bus.RecParityErr_o), 32'd0);
        @(negedge clk);
        chk("rs_valid_drop", 32'(bus.RecValid_o), 32'd0);
        chk("rs_err_cnt", 32'(bus.ErrCnt_o), 32'd2);
        chk("rs_pkt_cnt", 32'(bus.PktCnt_o), 32'd1);

        // Stray BODY, then last-oscillator packet raising RoundDone on accept
        do_reset();
        bus.RecReady_i = 1'b0;
        push(32'h4000_0001);
        repeat (2) @(negedge clk);
        chk("gb_err_cnt", 32'(bus.ErrCnt_o), 32'd1);
        chk("gb_valid", 32'(bus.RecValid_o), 32'd0);
        chk("gb_pkt_cnt", 32'(bus.PktCnt_o), 32'd0);
        push_pkt(32'h0000_0078, 32'h4000_ABCD, 32'hC000_0004);
        wait_valid(n);
        chk("rd_osc", 32'(bus.RecOsc_o), 32'd24);
        chk("rd_round_stalled", 32'(bus.RoundDone_o), 32'd0);
        bus.RecReady_i = 1'b1;
        #1;
        chk("rd_round_accept", 32'(bus.RoundDone_o), 32'd1);
        @(negedge clk);
        chk("rd_round_after", 32'(bus.RoundDone_o), 32'd0);
        chk("rd_pkt_cnt", 32'(bus.PktCnt_o), 32'd1);
        chk("rd_err_cnt", 32'(bus.ErrCnt_o), 32'd1);

        // Mid-packet reset discards the partial packet and clears counters
        do_reset();
        push_pkt(32'h0000_0143, 32'h4000_ABCD, 32'hC000_0008);
        wait_valid(n);
        @(negedge clk);
        chk("mr_pre_pkt", 32'(bus.PktCnt_o), 32'd1);
        chk("mr_pre_err", 32'(bus.ErrCnt_o), 32'd1);
        push(32'h0000_0143);
        push(32'h4000_ABCD);
        repeat (2) @(negedge clk);
        base = pop_cnt;
        rstn = 1'b0;
        push_pkt(32'h0000_0041, 32'h4000_ABCD, 32'hC000_0004);
        #1;
        chk("mr_fifo_rd", 32'(bus.FifoRd_o), 32'd0);
        chk("mr_valid", 32'(bus.RecValid_o), 32'd0);
        chk("mr_pkt_cnt", 32'(bus.PktCnt_o), 32'd0);
        chk("mr_err_cnt", 32'(bus.ErrCnt_o), 32'd0);
        chk("mr_rec_id", 32'(bus.RecId_o), 32'd0);
        @(negedge clk);
        chk("mr_no_pops", 32'(pop_cnt - base), 32'd0);
        rstn = 1'b1;
        wait_valid(n);
        chk("mr_latency", 32'(n), 32'd3);
        chk("mr_id", 32'(bus.RecId_o), 32'd2);
        chk("mr_osc", 32'(bus.RecOsc_o), 32'd1);
        chk("mr_data", 32'(bus.RecData_o), 32'hABCD);
        chk("mr_frame_err", 32'(bus.RecFrameErr_o), 32'd0);
        chk("mr_parity_err", 32'(bus.RecParityErr_o), 32'd0);
        @(negedge clk);
        chk("mr_post_pkt", 32'(bus.PktCnt_o), 32'd1);
        chk("mr_post_err", 32'(bus.ErrCnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logic_ni_rx.md
Name: logic_ni_rx

Overview:
- Receive end of the readout-network packet stream that the per-domain logic NI ALUs write into the shared packet FIFO.
- Pops 32-bit words from a first-word-fall-through FIFO and reassembles HEAD/BODY/TAIL triples into one record: ID, oscillator index and 16-bit count.
- Checks framing and the parity bits that can be recomputed from the transmitted data.
- Presents each record on a valid/ready port to the host-side result buffer and keeps saturating packet and error counters.

Parameters:
- NumOsc, 25, oscillators per NI; an Osc index of NumOsc-1 marks the last packet of a token round.
- CntWidth, 16, width of the packet and error counters.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- FifoEmpty_i  input  1  packet FIFO empty
- FifoRd_o  output  1  pop strobe; FIFO is FWFT, so FifoRdData_i is valid whenever FifoEmpty_i=0
- FifoRdData_i  input  32  head-of-FIFO word
- RecValid_o  output  1  record valid
- RecReady_i  input  1  consumer ready
- RecId_o  output  5  NI ID
- RecOsc_o  output  5  oscillator index
- RecData_o  output  16  count bits [23:8]
- RecParityErr_o  output  1  parity mismatch
- RecFrameErr_o  output  1  nonzero reserved bits, or partial packet preceding this one
- RoundDone_o  output  1  one-cycle pulse when a record with RecOsc_o==NumOsc-1 is accepted
- PktCnt_o  output  CntWidth  records accepted, saturating
- ErrCnt_o  output  CntWidth  error events, saturating

Behaviour:
- Word types are taken from bits [31:30]:
  - 00 = HEAD, with ID in [9:5] and Osc in [4:0]; reserved bits [29:10] must be 0.
  - 01 = BODY, with data in [15:0]; reserved bits [29:16] must be 0.
  - 11 = TAIL, with parity in [7:0]; reserved bits [29:8] must be 0.
  - 10 = illegal.
- States: W_HEAD, W_BODY, W_TAIL, OUT. Reset state is W_HEAD.
- FifoRd_o = ~FifoEmpty_i & (state != OUT). One word is consumed per cycle.
- W_HEAD:
  - HEAD: latch ID and Osc, then go to W_BODY.
  - Any other type: drop the word, ErrCnt +1, stay in W_HEAD.
- W_BODY:
  - BODY: latch data, then go to W_TAIL.
  - HEAD: resync. Latch the new head, set the sticky frame flag, ErrCnt +1, stay in W_BODY.
  - TAIL or illegal: drop, ErrCnt +1, go to W_HEAD.
- W_TAIL:
  - TAIL: compute the record, then go to OUT.
  - HEAD: resync as in W_BODY, go to W_BODY.
  - BODY or illegal: drop, ErrCnt +1, go to W_HEAD.
- Parity check: only parity[3] and parity[2] are checked; the other bits depend on data bits [7:0], which are not transmitted.
  - Expected parity[3] = ~^data[23:18].
  - Expected parity[2] = ~^data[17:12].
  - data[23:8] corresponds to the BODY payload [15:0].
  - RecParityErr_o = mismatch on either checked bit.
- RecFrameErr_o = sticky resync flag OR any nonzero reserved bits in the three words. The sticky flag clears when the record is accepted.
- Latency: TAIL popped in cycle N gives RecValid_o=1 in cycle N+1.
- Output hold:
  - Record fields are registered and stable while RecValid_o=1.
  - The state leaves OUT on RecValid_o & RecReady_i, returning to W_HEAD. The next pop happens in that same cycle + 1.
  - No pops occur while in OUT.
- Counters:
  - PktCnt +1 on each accept.
  - ErrCnt +1 per dropped or resync word, and +1 on an accept where RecParityErr_o or RecFrameErr_o is set.
  - If both increments fall in one cycle, ErrCnt adds 2.
  - Both counters saturate at all-ones.
- RoundDone_o is asserted in the accept cycle itself when RecOsc_o == NumOsc-1. It is combinational from the registered state.
- Reset (asynchronous, any state, including mid-packet or in OUT):
  - All outputs and counters go to 0.
  - The partial packet is discarded.
  - FifoRd_o=0 while rstn=0.

Decomposition:
- Shared package logic_ni_pkg holds:
  - type codes PKT_HEAD=2'b00, PKT_BODY=2'b01, PKT_TAIL=2'b11;
  - field LSB/MSB constants;
  - the state encoding.
- The NI transmitter uses the same package.
- One sub-module, logic_ni_parity_chk: combinational check of the BODY payload and TAIL parity byte, returning the error bit.

Test Plan:
- Good packet: HEAD 0x00000143, BODY 0x4000ABCD, TAIL 0xC0000004, RecReady_i=1 -> after TAIL pop, RecValid_o=1 for one cycle with RecId_o=10, RecOsc_o=3, RecData_o=0xABCD, both error bits 0; PktCnt_o=1.
- Parity error: same packet but TAIL 0xC0000008 -> RecParityErr_o=1, ErrCnt_o=1, PktCnt_o=1.
- Backpressure: good packet followed by a second packet, RecReady_i=0 for 5 cycles -> FifoRd_o=0 and fields stable for those 5 cycles; second packet pops start the cycle after the accept.
- Resync: HEAD(ID 2, Osc 0), HEAD(ID 2, Osc 1), BODY, TAIL -> a single record with RecOsc_o=1 and RecFrameErr_o=1; ErrCnt_o=2.
- Round and garbage:
  - Stray BODY 0x40000001 in W_HEAD -> dropped, ErrCnt_o=1.
  - Then a packet with Osc=24 -> RoundDone_o pulses in the accept cycle.
- Mid-packet reset: assert rstn=0 after the BODY pop -> outputs and counters go to 0; after release, a fresh good packet decodes correctly.
